// File: rtl/t_register_counter.sv
// Multi-mode WIDTH-bit register built on T-flip-flop semantics: per-bit toggle,
// up/down count against a programmable terminal value (wrap or saturate), load and clear.
module t_register_counter #(
   parameter int unsigned          WIDTH    = 8,
   parameter logic [WIDTH-1:0]     MAX_VAL  = '1,
   parameter bit                   SATURATE = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en_i,
   input  logic [2:0]       mode_i,
   input  logic [WIDTH-1:0] t_mask_i,
   input  logic [WIDTH-1:0] load_val_i,
   output logic [WIDTH-1:0] q_o,
   output logic             at_max_o,
   output logic             at_zero_o,
   output logic             wrap_o
);

   typedef enum logic [2:0] {
      ModeHold   = 3'b000,
      ModeToggle = 3'b001,
      ModeUp     = 3'b010,
      ModeDown   = 3'b011,
      ModeLoad   = 3'b100,
      ModeClear  = 3'b101
   } mode_e;

   logic [WIDTH-1:0] q_q, q_d;
   logic             wrap_q, wrap_d;

   always_comb begin
      q_d    = q_q;
      wrap_d = 1'b0;
      if (en_i) begin
         case (mode_i)
            ModeHold:   q_d = q_q;
            ModeToggle: q_d = q_q ^ t_mask_i;
            // q can sit above MAX_VAL after a toggle; treat that as terminal too.
            ModeUp: begin
               if (q_q < MAX_VAL) begin
                  q_d = q_q + 1'b1;
               end else if (SATURATE) begin
                  q_d = MAX_VAL;
               end else begin
                  q_d    = '0;
                  wrap_d = 1'b1;
               end
            end
            ModeDown: begin
               if (q_q != '0) begin
                  q_d = q_q - 1'b1;
               end else if (SATURATE) begin
                  q_d = '0;
               end else begin
                  q_d    = MAX_VAL;
                  wrap_d = 1'b1;
               end
            end
            ModeLoad:  q_d = (load_val_i > MAX_VAL) ? MAX_VAL : load_val_i;
            ModeClear: q_d = '0;
            default:   q_d = q_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_q    <= '0;
         wrap_q <= 1'b0;
      end else begin
         q_q    <= q_d;
         wrap_q <= wrap_d;
      end
   end

   assign q_o       = q_q;
   assign wrap_o    = wrap_q;
   assign at_max_o  = (q_q >= MAX_VAL);
   assign at_zero_o = (q_q == '0);

endmodule
